ex_issue_stage: RTL
===================

// Module: ex_issue_stage
// PURPOSE
//  ID->EX pipeline register and operand builder directly upstream of the ALU. Captures the decoded
//  instruction, resolves RAW hazards by forwarding (EX, MEM) or by a one-cycle load-use bubble, selects
//  operand1/operand2 per opcode and presents registered opcode/func3/func7/operands to the ALU.
//  Handles branch-flush bubbles and downstream back-pressure.
// PARAMETERS
//  XLEN        32  datapath width
//  RA_W        5   register index width
//  CNT_W       16  width of stall-cycle counter
// PORTS
//  clk            in   1      clock
//  rst            in   1      asynchronous, active-high reset
//  id_valid       in   1      decode offers an instruction
//  id_ready       out  1      stage accepts the offer this cycle
//  id_opcode      in   7      opcode
//  id_func3       in   3      func3
//  id_func7       in   7      func7 (imm[11:5] for OP_I shifts)
//  id_rs1,id_rs2  in   RA_W   source register indices
//  id_rd          in   RA_W   destination index
//  id_rs1_data    in   XLEN   register-file read data rs1 (regfile bypasses same-cycle WB)
//  id_rs2_data    in   XLEN   register-file read data rs2
//  id_imm         in   XLEN   sign-extended immediate (U-type: already shifted)
//  id_pc          in   XLEN   word-addressed PC
//  ex_alu_out     in   XLEN   current ALU result (feedback for EX forwarding)
//  mem_rd         in   RA_W   MEM-stage destination
//  mem_we         in   1      MEM-stage writes rd
//  mem_data       in   XLEN   MEM-stage final result (incl. load data)
//  mem_stall      in   1      downstream not ready: hold EX register
//  flush          in   1      branch taken: discard the decode offer
//  ex_valid       out  1      EX register holds a real instruction
//  ex_opcode      out  7      to ALU
//  ex_func3       out  3      to ALU
//  ex_func7       out  7      to ALU
//  ex_operand1    out  XLEN   to ALU
//  ex_operand2    out  XLEN   to ALU
//  ex_store_data  out  XLEN   forwarded rs2 for OP_S
//  ex_rd          out  RA_W   destination
//  ex_reg_write   out  1      1 for OP_I,OP_R,OP_L,LUI,AUIPC,JAL,JALR with rd!=0
//  ex_pc          out  XLEN   PC of EX instruction
//  stall_cnt      out  CNT_W  saturating count of load-use bubble cycles
// BEHAVIOUR
//  - Reset: all ex_* outputs 0 (opcode 0 = bubble, ALU yields 0), ex_valid=0, stall_cnt=0.
//  - Latency: 1 cycle from accepted offer to ex_* outputs.
//  - load_use = ex_valid & ex_opcode==OP_L & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & rs2 used)).
//    rs2 used for OP_R, OP_B, OP_S only; rs1 unused for LUI, AUIPC, JAL.
//  - id_ready = !mem_stall & (!load_use | flush).
//  - Priority each cycle: rst > mem_stall (hold all regs) > flush (load bubble) > load_use (load
//    bubble, stall_cnt++ saturating at all-ones) > id_valid (capture) > load bubble.
//  - Forwarding per source (index 0 never forwarded, reads 0): EX match (ex_valid & ex_reg_write &
//    ex_rd==rs, not OP_L) -> ex_alu_out; else MEM match (mem_we & mem_rd==rs) -> mem_data; else regfile.
//  - operand1 = id_pc for AUIPC, JAL, JALR; else fwd rs1.
//  - operand2 = id_imm for OP_I, OP_L, OP_S, LUI, AUIPC; fwd rs2 for OP_R, OP_B; 0 otherwise.
//  - ex_store_data = fwd rs2 for OP_S, else 0. Unknown opcode: captured as-is, ex_reg_write=0.
//  - Reset mid-stall: all state cleared, id_ready=1 the cycle after rst drops.
// STRUCTURE
//  - Opcode/func3/func7 constants and TRUE/FALSE: const.svh (shared with ALU, decoder).
//  - Sub-module fwd_select: one instance per source operand, combinational forwarding mux.
//  - Top: hazard detect, operand select, EX register, stall counter.
// TESTING
//  1 Reset: rst=1 mid-stream -> next edge ex_valid=0, ex_opcode=0, stall_cnt=0; id_ready=1 after release.
//  2 EX fwd: ADDI x5,x0,7 then ADD x6,x5,x5 -> ex_operand1=ex_operand2=7 (from ex_alu_out), no bubble.
//  3 Load-use: LW x5 then ADD x6,x5,x1 -> id_ready=0 one cycle, bubble (opcode 0), stall_cnt=1;
//    next cycle ADD gets x5 from mem_data=0x1234.
//  4 MEM over regfile: mem_we=1,mem_rd=3,mem_data=0xA, regfile x3=0x5, SUB x4,x3,x0 -> operand1=0xA.
//  5 x0 rule: mem_we=1,mem_rd=0,mem_data=0xFF, ADD x1,x0,x0 -> operands 0, ex_reg_write=0 for rd=0.
//  6 Control: flush=1 with id_valid -> bubble, id_ready=1; mem_stall=1 3 cycles -> ex_* unchanged;
//    JAL at pc=0x40 -> operand1=0x40 (ALU link 0x41).

Source files
------------

// File: rtl/ex_issue_stage_pkg.sv
// Shared widths, opcode constants, EX-register payload and opcode classification helpers
// for the ID->EX issue stage.
package ex_issue_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_L   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_S   = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_B   = 7'b1100011;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic             valid;
        logic [OPC_W-1:0] opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [XLEN-1:0]  operand1;
        logic [XLEN-1:0]  operand2;
        logic [XLEN-1:0]  store_data;
        logic [RA_W-1:0]  rd;
        logic             reg_write;
        logic [XLEN-1:0]  pc;
    } ex_reg_t;

    function automatic logic rs1_used(input logic [OPC_W-1:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic rs2_used(input logic [OPC_W-1:0] op);
        return (op == OP_R || op == OP_B || op == OP_S);
    endfunction

    function automatic logic writes_rd(input logic [OPC_W-1:0] op);
        return (op == OP_I || op == OP_R || op == OP_L || op == LUI ||
                op == AUIPC || op == JAL || op == JALR);
    endfunction

endpackage

// File: rtl/ex_issue_stage_fwd.sv
// Combinational forwarding mux for one source operand: EX result, then MEM result, then regfile.
module ex_issue_stage_fwd
    import ex_issue_stage_pkg::*;
(
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_fwd_en,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] fwd_c
);

    always_comb begin
        fwd_c = rf_data;
        if (rs == '0) begin
            fwd_c = '0;
        end else if (ex_fwd_en && ex_rd == rs) begin
            fwd_c = ex_alu_out;
        end else if (mem_we && mem_rd == rs) begin
            fwd_c = mem_data;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX pipeline register: hazard detection, operand forwarding/selection, load-use bubbles
// and a saturating load-use stall counter.
module ex_issue_stage
    import ex_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [2:0]        id_func3,
    input  logic [6:0]        id_func7,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [2:0]        ex_func3,
    output logic [6:0]        ex_func7,
    output logic [XLEN-1:0]   ex_operand1,
    output logic [XLEN-1:0]   ex_operand2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_reg_write,
    output logic [XLEN-1:0]   ex_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    ex_reg_t          ex_q;
    ex_reg_t          cap;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             ex_fwd_en;
    logic [XLEN-1:0]  rs1_fwd;
    logic [XLEN-1:0]  rs2_fwd;

    // A load in EX has no result yet, so it may only be forwarded from MEM.
    assign ex_fwd_en = ex_q.valid && ex_q.reg_write && (ex_q.opcode != OP_L);

    ex_issue_stage_fwd u_fwd_rs1 (
        .rs         (id_rs1),
        .rf_data    (id_rs1_data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (ex_q.rd),
        .ex_alu_out (ex_alu_out),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .fwd_c      (rs1_fwd)
    );

    ex_issue_stage_fwd u_fwd_rs2 (
        .rs         (id_rs2),
        .rf_data    (id_rs2_data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (ex_q.rd),
        .ex_alu_out (ex_alu_out),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .fwd_c      (rs2_fwd)
    );

    always_comb begin
        load_use = FALSE;
        if (ex_q.valid && ex_q.opcode == OP_L && ex_q.rd != '0) begin
            load_use = (rs1_used(id_opcode) && ex_q.rd == id_rs1) ||
                       (rs2_used(id_opcode) && ex_q.rd == id_rs2);
        end
        id_ready = !mem_stall && (!load_use || flush);
    end

    // Operand builder for the instruction offered by decode.
    always_comb begin
        cap            = '0;
        cap.valid      = TRUE;
        cap.opcode     = id_opcode;
        cap.func3      = id_func3;
        cap.func7      = id_func7;
        cap.rd         = id_rd;
        cap.pc         = id_pc;
        cap.reg_write  = writes_rd(id_opcode) && (id_rd != '0);
        cap.operand1   = (id_opcode == AUIPC || id_opcode == JAL || id_opcode == JALR)
                         ? id_pc : rs1_fwd;
        case (id_opcode)
            OP_I, OP_L, OP_S, LUI, AUIPC: cap.operand2 = id_imm;
            OP_R, OP_B:                   cap.operand2 = rs2_fwd;
            default:                      cap.operand2 = '0;
        endcase
        cap.store_data = (id_opcode == OP_S) ? rs2_fwd : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else if (!mem_stall) begin
            if (flush) begin
                ex_q <= '0;
            end else if (load_use) begin
                ex_q <= '0;
                if (stall_cnt_q != '1) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
            end else if (id_valid) begin
                ex_q <= cap;
            end else begin
                ex_q <= '0;
            end
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_opcode     = ex_q.opcode;
    assign ex_func3      = ex_q.func3;
    assign ex_func7      = ex_q.func7;
    assign ex_operand1   = ex_q.operand1;
    assign ex_operand2   = ex_q.operand2;
    assign ex_store_data = ex_q.store_data;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_pc         = ex_q.pc;
    assign stall_cnt     = stall_cnt_q;

endmodule
